// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU (add/sub/mul/div/logic) with valid/ready handshake on both sides.
// Latency: single-cycle ops 1 cycle, MUL/DIV WIDTH+1 cycles; one operation in flight at a time.
// Backpressure: in_ready only while IDLE; the result is held in DONE until out_ready. Divider built only under SEQ_ALU_DIV_EN.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_MUL  = 4'd1;
    localparam logic [3:0] OP_DIV  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   mag_q;     // |A| as multiplicand, or |B| as divisor
    logic               cin_q;
    logic [3:0]         sel_q;
    logic [2*WIDTH-1:0] acc_q;     // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_carry;
    logic               fin_ovf;
    logic               fin_err;
    logic [4:0]         fin_flags;

    assign in_ready = (state == S_IDLE);

    // Magnitudes: MIN maps to 2^(WIDTH-1), which is still exact as an unsigned value.
    assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

    // Unsigned shift-add multiply on magnitudes; sign applied once at the end.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_prod = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_q : acc_q;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    // Restoring step: shift in the next dividend bit, subtract divisor when it fits.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, mag_q});
    assign div_diff  = div_trial[WIDTH-1:0] - mag_q;
    assign div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
`endif

    assign add_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

    // Final result selection from latched operands and the iteration register.
    always_comb begin
        fin_res   = '0;
        fin_hi    = '0;
        fin_carry = 1'b0;
        fin_ovf   = 1'b0;
        fin_err   = 1'b0;
        case (sel_q)
            OP_ADD: begin
                fin_res   = add_sum[WIDTH-1:0];
                fin_carry = add_sum[WIDTH];
                fin_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                fin_res   = sub_sum[WIDTH-1:0];
                fin_carry = sub_sum[WIDTH];
                fin_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL: begin
                fin_res = mul_prod[WIDTH-1:0];
                fin_hi  = mul_prod[2*WIDTH-1:WIDTH];
                fin_ovf = (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_res = '1;
                    fin_hi  = a_q;
                    fin_err = 1'b1;
                end else begin
                    // MIN / -1 naturally yields MIN with zero remainder; only the flag is special.
                    fin_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    fin_hi  = a_q[WIDTH-1] ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    fin_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
                end
            end
`endif
            OP_NAND: fin_res = ~(a_q & b_q);
            OP_NOR:  fin_res = ~(a_q | b_q);
            OP_NOT:  fin_res = ~a_q;
            OP_XOR:  fin_res = a_q ^ b_q;
            default: fin_err = 1'b1;
        endcase
    end

    assign fin_flags = {fin_err, fin_ovf, fin_carry, fin_res[WIDTH-1], (fin_res == '0)};

    // Control FSM, operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_q     <= '0;
            cin_q     <= 1'b0;
            sel_q     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        cin_q <= cin;
                        sel_q <= sel;
                        state <= S_BUSY;
                        if (sel == OP_MUL) begin
                            cnt   <= CW'(WIDTH);
                            mag_q <= abs_a;
                            acc_q <= {{WIDTH{1'b0}}, abs_b};
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (sel == OP_DIV) begin
                            cnt   <= CW'(WIDTH);
                            mag_q <= abs_b;
                            acc_q <= {{WIDTH{1'b0}}, abs_a};
                        end
`endif
                        else begin
                            cnt <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
`ifdef SEQ_ALU_DIV_EN
                        acc_q <= (sel_q == OP_DIV) ? div_next : mul_next;
`else
                        acc_q <= mul_next;
`endif
                    end else begin
                        result    <= fin_res;
                        result_hi <= fin_hi;
                        flags     <= fin_flags;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model.
// Latency: measured per operation from the acceptance edge to out_valid.
// Backpressure: exercises out_ready held low with a pending in_valid, and reset during MUL.
module tb_seq_alu;
    localparam int     W    = 16;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a      = '0;
    logic [W-1:0] op_b      = '0;
    logic         cin       = 1'b0;
    logic [3:0]   sel       = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [4:0]   flags;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results from signed integer arithmetic, flags from value ranges.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [3:0] s, output logic [W-1:0] r, output logic [W-1:0] rh,
                         output logic [4:0] f, output int lat);
        longint sa, sb, m;
        logic carry, ovf, err;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; rh = '0; carry = 1'b0; ovf = 1'b0; err = 1'b0; lat = 1;
        case (s)
            4'd0: begin
                m     = longint'(a) + longint'(b) + longint'(c);
                r     = m[W-1:0];
                carry = m[W];
                ovf   = (sa + sb + longint'(c) > SMAX) || (sa + sb + longint'(c) < SMIN);
            end
            4'd1: begin
                m   = sa * sb;
                r   = m[W-1:0];
                rh  = m[2*W-1:W];
                ovf = (m > SMAX) || (m < SMIN);
                lat = W + 1;
            end
            4'd2: begin
`ifdef SEQ_ALU_DIV_EN
                lat = W + 1;
                if (b == '0) begin
                    r = '1; rh = a; err = 1'b1;
                end else if (sa == SMIN && sb == -1) begin
                    r = a; rh = '0; ovf = 1'b1;
                end else begin
                    m  = sa / sb;
                    r  = m[W-1:0];
                    m  = sa % sb;
                    rh = m[W-1:0];
                end
`else
                err = 1'b1;
`endif
            end
            4'd3: r = ~(a & b);
            4'd4: r = ~(a | b);
            4'd5: r = ~a;
            4'd6: r = a ^ b;
            4'd7: begin
                m     = sa - sb;
                r     = m[W-1:0];
                carry = (a >= b);
                ovf   = (m > SMAX) || (m < SMIN);
            end
            default: err = 1'b1;
        endcase
        f = {err, ovf, carry, r[W-1], (r == '0)};
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check({tag, ".ready_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [3:0] s);
        logic [W-1:0] er, erh;
        logic [4:0]   ef;
        int           elat, lat;
        model(a, b, c, s, er, erh, ef, elat);
        wait_ready(tag);
        op_a = a; op_b = b; cin = c; sel = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sel = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},       lat,       elat);
        check({tag, ".result"},    result,    er);
        check({tag, ".result_hi"}, result_hi, erh);
        check({tag, ".flags"},     flags,     ef);
        check({tag, ".busy"},      in_ready,  0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".taken"},     out_valid, 0);
        check({tag, ".idle"},      in_ready,  1);
    endtask

    initial begin
        logic [W-1:0] er, erh, av, bv;
        logic [4:0]   ef;
        int           elat, n;
        logic         seen;
        logic [3:0]   s;
        logic [W-1:0] specials [4];
        specials[0] = 16'h0000; specials[1] = 16'hFFFF;
        specials[2] = 16'h8000; specials[3] = 16'h7FFF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.result",    result,    0);
        check("rst.result_hi", result_hi, 0);
        check("rst.flags",     flags,     0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready",  in_ready,  1);

        // Directed scenarios
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 4'd0);
        run_op("add_cin",   16'hFFFF, 16'h0000, 1'b1, 4'd0);
        run_op("sub_borrow",16'h0001, 16'h0002, 1'b1, 4'd7);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 4'd7);
        run_op("mul_neg",   16'hFFFD, 16'h0100, 1'b0, 4'd1);
        run_op("mul_ovf",   16'h4000, 16'h0004, 1'b0, 4'd1);
        run_op("mul_min",   16'h8000, 16'h8000, 1'b0, 4'd1);
        run_op("div_neg",   16'hFFF9, 16'h0002, 1'b0, 4'd2);
        run_op("div_zero",  16'h1234, 16'h0000, 1'b0, 4'd2);
        run_op("div_minm1", 16'h8000, 16'hFFFF, 1'b0, 4'd2);
        run_op("nand",      16'hF0F0, 16'hFF00, 1'b0, 4'd3);
        run_op("nor",       16'hF0F0, 16'h0F00, 1'b0, 4'd4);
        run_op("not",       16'hFFFF, 16'h1234, 1'b0, 4'd5);
        run_op("xor",       16'hA5A5, 16'h5A5A, 1'b0, 4'd6);
        run_op("illegal",   16'h1234, 16'h5678, 1'b1, 4'hC);

        // Backpressure: result held while a second request waits
        model(16'h00FF, 16'h0F0F, 1'b0, 4'd6, er, erh, ef, elat);
        wait_ready("bp");
        op_a = 16'h00FF; op_b = 16'h0F0F; sel = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 16'h0003; op_b = 16'h0004; cin = 1'b0; sel = 4'd0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp.lat", n, elat);
        for (int i = 0; i < 10; i++) begin
            check("bp.hold_valid",  out_valid, 1);
            check("bp.hold_result", result,    er);
            check("bp.hold_flags",  flags,     ef);
            check("bp.hold_ready",  in_ready,  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release_valid", out_valid, 0);
        check("bp.release_ready", in_ready,  1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.second_accept", in_ready, 0);
        model(16'h0003, 16'h0004, 1'b0, 4'd0, er, erh, ef, elat);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp.second_lat",    n,      elat);
        check("bp.second_result", result, er);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a MUL
        wait_ready("rstmul");
        op_a = 16'h1234; op_b = 16'h0567; sel = 4'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmul.out_valid", out_valid, 0);
        check("rstmul.result",    result,    0);
        check("rstmul.result_hi", result_hi, 0);
        check("rstmul.flags",     flags,     0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rstmul.no_pulse", seen,     0);
        check("rstmul.in_ready", in_ready, 1);
        run_op("rstmul.next", 16'h1234, 16'h0567, 1'b0, 4'd1);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 9));
            s = (n < 8) ? 4'(n) : 4'($urandom_range(8, 15));
            av = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            bv = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            run_op("rand", av, bv, 1'($urandom), s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
